// File: rtl/mem_arb_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM state codes and grant IDs.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_I = ST_BUSY_I,
    BUSY_D = ST_BUSY_D,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between I- and D-cache requests.
// ARB_RR_EN selects round-robin on contention; otherwise D always beats I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef ARB_RR_EN
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_id    = d_req ? GNT_D : GNT_I;
    // On contention the side that did not win last time goes first.
    if (i_req && d_req) begin
      gnt_id = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_id    = d_req ? GNT_D : GNT_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache.
// Define ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              state_reg, state_next;
  logic                read_reg, read_next;
  logic                write_reg, write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                gnt_valid, gnt_id;
  logic                last_grant;

  mem_arb_pick u_pick (
    .i_req      (i_read | i_write),
    .d_req      (d_read | d_write),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

`ifdef ARB_RR_EN
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      last_grant_reg <= GNT_I;
    end else if (state_reg == IDLE && gnt_valid) begin
      last_grant_reg <= gnt_id;
    end
  end

  assign last_grant = last_grant_reg;
`else
  assign last_grant = GNT_I;
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg <= IDLE;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // The request is latched at grant; client inputs are ignored until DONE.
  always_comb begin
    state_next = state_reg;
    read_next  = read_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt_id == GNT_D) begin
            state_next = BUSY_D;
            read_next  = d_read;
            write_next = d_write;
            addr_next  = d_addr;
            wdata_next = d_wdata;
          end else begin
            state_next = BUSY_I;
            read_next  = i_read;
            write_next = i_write;
            addr_next  = i_addr;
            wdata_next = i_wdata;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_next = DONE;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready is suppressed while reset is asserted so an aborted transfer never completes.
  assign i_ready = (state_reg == BUSY_I) && mem_ready && !proc_reset;
  assign d_ready = (state_reg == BUSY_D) && mem_ready && !proc_reset;

  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_read  = read_reg;
  assign mem_write = write_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: cycle-level arbitration model,
// behavioural memory, and a decoupled monitor comparing grants and ready pulses.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  bit run_i = 0, run_d = 0, hold = 0, spur = 0;
  int cyc = 0;
  int n_checks = 0, n_pass = 0;

  typedef struct {
    int            cyc;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;

  typedef struct {
    int            cyc;
    bit            side;
    logic [DW-1:0] rdata;
  } rdy_t;

  grant_t gq[$];
  rdy_t   rq[$];
  logic [DW-1:0] store [logic [AW-1:0]];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7)) * 28'h0000040;
    return a;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
    if (store.exists(a)) return store[a];
    return {4{4'hA, a}};
  endfunction

  always @(negedge clk) begin
    assert (!(i_read && i_write) && !(d_read && d_write))
      else $error("FAIL illegal_rw: client raised read and write together");
  end

  // I-cache client: line reads held until i_ready, optional back-to-back reissue.
  initial begin
    bit rdy, go, act;
    act = 0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    forever begin
      @(negedge clk);
      rdy = i_ready; go = run_i;
      @(posedge clk); #1;
      if (act && rdy) begin act = 0; i_read = 0; end
      if (!act && go && $urandom_range(0, 2) == 0) begin
        act = 1; i_read = 1; i_addr = rand_addr();
      end
    end
  end

  // D-cache client: reads and write-backs; scrambles its inputs while waiting.
  initial begin
    bit rdy, go, act;
    act = 0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    forever begin
      @(negedge clk);
      rdy = d_ready; go = run_d;
      @(posedge clk); #1;
      if (act && rdy) begin act = 0; d_read = 0; d_write = 0; end
      else if (act && $urandom_range(0, 3) == 0) begin
        d_addr = rand_addr(); d_wdata = rand_data();
      end
      if (!act && go && $urandom_range(0, 2) == 0) begin
        act = 1; d_addr = rand_addr(); d_wdata = rand_data();
        if ($urandom_range(0, 2) == 0) d_write = 1; else d_read = 1;
      end
    end
  end

  // Slow memory with random latency; may echo a stray mem_ready right after completion.
  initial begin
    bit req, rst, hd, sp, serving, dbl, s_wr;
    int cnt;
    logic [AW-1:0] a_smp, s_addr;
    logic [DW-1:0] w_smp, s_wd;
    serving = 0; dbl = 0; cnt = 0; s_wr = 0; s_addr = '0; s_wd = '0;
    mem_ready = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      req = mem_read | mem_write; rst = proc_reset; hd = hold; sp = spur;
      a_smp = mem_addr; w_smp = mem_wdata;
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = rand_data();
      if (rst) begin serving = 0; dbl = 0; end
      if (sp) mem_ready = 1;
      else if (!rst) begin
        if (serving) begin
          if (!hd) cnt--;
          if (cnt == 0) begin
            mem_ready = 1; serving = 0;
            if (s_wr) store[s_addr] = s_wd;
            else mem_rdata = mem_lookup(s_addr);
            dbl = ($urandom_range(0, 1) == 1);
          end
        end else if (dbl) begin
          mem_ready = 1; dbl = 0;
        end else if (req) begin
          serving = 1; cnt = $urandom_range(1, 6);
          s_wr = mem_write; s_addr = a_smp; s_wd = w_smp;
        end
      end
    end
  end

  // Reference model: a transfer occupies the memory until its completion pulse,
  // is followed by one dead cycle, and a new grant reaches memory one cycle after
  // the arbiter is free and sees a request.
  initial begin
    bit busy, bside, ireq, dreq, w;
`ifdef ARB_RR_EN
    bit last_g;
    last_g = 0;
`endif
    int free_cyc;
    busy = 0; bside = 0; free_cyc = 0;
    forever begin
      @(negedge clk);
      ireq = i_read | i_write;
      dreq = d_read | d_write;
      if (proc_reset) begin
        busy = 0; free_cyc = cyc + 1;
`ifdef ARB_RR_EN
        last_g = 0;
`endif
      end else if (busy && mem_ready) begin
        rq.push_back('{cyc, bside, mem_rdata});
        busy = 0; free_cyc = cyc + 2;
      end else if (!busy && cyc >= free_cyc && (ireq || dreq)) begin
`ifdef ARB_RR_EN
        w = (ireq && dreq) ? ~last_g : dreq;
        last_g = w;
`else
        w = dreq;
`endif
        if (w) gq.push_back('{cyc + 1, d_read, d_write, d_addr, d_wdata});
        else   gq.push_back('{cyc + 1, i_read, i_write, i_addr, i_wdata});
        busy = 1; bside = w;
      end
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard queues.
  initial begin
    bit req, prev_req, prev_rst, in_x;
    grant_t cur;
    rdy_t r;
    prev_req = 0; prev_rst = 1; in_x = 0;
    cur = '{0, 0, 0, '0, '0};
    forever begin
      @(negedge clk); #1;
      req = mem_read | mem_write;
      if (cyc >= 1) begin
        if (prev_rst)
          chk(!mem_read && !mem_write && mem_addr == '0 && mem_wdata == '0 && !i_ready && !d_ready,
              "reset_clear", {mem_read, mem_write, i_ready, d_ready, mem_addr}, '0);
        if (req && !prev_req) begin
          if (gq.size() == 0) chk(0, "unexpected_grant", DW'(mem_addr), '0);
          else begin
            cur = gq.pop_front();
            chk(cur.cyc == cyc, "grant_cycle", DW'(cyc), DW'(cur.cyc));
            chk(mem_read == cur.rd && mem_write == cur.wr && mem_addr == cur.addr &&
                mem_wdata == cur.wdata, "grant_req", {mem_read, mem_write, mem_addr},
                {cur.rd, cur.wr, cur.addr});
            in_x = 1;
          end
        end else if (req && in_x) begin
          chk(mem_read == cur.rd && mem_write == cur.wr && mem_addr == cur.addr &&
              mem_wdata == cur.wdata, "hold_req", DW'(mem_addr), DW'(cur.addr));
        end
        if (!req) in_x = 0;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
          chk(0, "missing_grant", '0, DW'(gq[0].addr));
          void'(gq.pop_front());
        end
        if (i_ready || d_ready) begin
          if (rq.size() == 0) chk(0, "spurious_ready", {i_ready, d_ready}, '0);
          else begin
            r = rq.pop_front();
            chk(r.cyc == cyc && d_ready == r.side && i_ready == !r.side, "ready_route",
                {i_ready, d_ready}, {!r.side, r.side});
            chk((r.side ? d_rdata : i_rdata) == r.rdata, "rdata",
                r.side ? d_rdata : i_rdata, r.rdata);
            $display("cycle %0d: %s-cache transfer complete, rdata=%h", cyc,
                     r.side ? "D" : "I", r.rdata);
          end
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
          chk(0, "missing_ready", '0, DW'(rq[0].side));
          void'(rq.pop_front());
        end
      end
      prev_req = req;
      prev_rst = proc_reset;
    end
  end

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!(i_read | i_write | d_read | d_write) && !mem_read && !mem_write &&
          gq.size() == 0 && rq.size() == 0) break;
    end
    chk(k < 400, "drain", DW'(k), 400);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    int k;
    proc_reset = 1; run_i = 1; run_d = 1;
    repeat (2) @(posedge clk);
    #1 proc_reset = 0;
    repeat (1500) @(posedge clk);
    #1 run_i = 0; run_d = 0;
    drain();
    // Stray completion pulses with nothing in flight must not reach either cache.
    spur = 1;
    repeat (6) begin @(posedge clk); #1; end
    spur = 0;
    repeat (3) begin @(posedge clk); #1; end
    // Abort an I-side transfer with reset while memory stalls, plus stray pulses.
    hold = 1; run_i = 1;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (mem_read) break;
    end
    chk(k < 200, "abort_setup", DW'(k), 200);
    repeat (3) begin @(posedge clk); #1; end
    spur = 1;
    @(posedge clk); #1;
    proc_reset = 1;
    @(posedge clk); #1;
    spur = 0;
    @(posedge clk); #1;
    proc_reset = 0; hold = 0; run_d = 1;
    repeat (800) @(posedge clk);
    #1 run_i = 0; run_d = 0;
    drain();
    chk(gq.size() == 0 && rq.size() == 0, "queues_empty", DW'(gq.size() + rq.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
